// File: rtl/dmem_if.sv
// Data-memory bus between the pipeline MEM stage (master) and the responder (slave).
interface dmem_if;
  logic        mem_w_en;
  logic        mem_r_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;
  logic [4:0]  wb_count;
  logic        wb_full;
  logic        wb_ovf;

  modport master (
    output mem_w_en, mem_r_en, mem_addr, mem_w_data,
    input  mem_r_data, wb_count, wb_full, wb_ovf
  );

  modport slave (
    input  mem_w_en, mem_r_en, mem_addr, mem_w_data,
    output mem_r_data, wb_count, wb_full, wb_ovf
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data memory behind a store write buffer with youngest-match read forwarding.
// Optional `DMEM_CYCLE_CNT_EN maps a free-running cycle counter at address 0xFFFF_FFF0.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WB_DEPTH   = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);
  localparam int         PW       = $clog2(WB_DEPTH);
  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam logic [4:0] FULL_CNT = 5'(WB_DEPTH);

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef logic [PW-1:0]         ptr_t;

  logic [31:0] mem     [WORDS];
  idx_t        wb_idx  [WB_DEPTH];
  logic [31:0] wb_data [WB_DEPTH];

  ptr_t        head, tail;
  logic [4:0]  count;
  logic        ovf;

  idx_t        idx;
  logic        is_cnt;
  logic        drain, space, enq, drop;
  logic [31:0] fwd;
  ptr_t        slot;
  logic        unused_addr_bits;

  assign idx              = bus.mem_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{bus.mem_addr[31:DEPTH_LOG2+2], bus.mem_addr[1:0]};

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign is_cnt         = (bus.mem_addr == 32'hFFFF_FFF0);
  assign bus.mem_r_data = is_cnt ? cycle_cnt : fwd;
`else
  assign is_cnt         = 1'b0;
  assign bus.mem_r_data = fwd;
`endif

  // A load owns the single array port, except a counter read which never touches the array.
  assign drain = (count != 5'd0) && !(bus.mem_r_en && !is_cnt);
  assign space = (count != FULL_CNT) || drain;
  assign enq   = bus.mem_w_en && !is_cnt && space;
  assign drop  = bus.mem_w_en && !is_cnt && !space;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (drain) head <= head + ptr_t'(1);
      if (enq)   tail <= tail + ptr_t'(1);
      count <= count + {4'b0, enq} - {4'b0, drain};
      ovf   <= ovf | drop;
    end
  end

  // Buffer entries and the array are pure storage: reset only discards them via the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      wb_idx[tail]  <= idx;
      wb_data[tail] <= bus.mem_w_data;
    end
    if (drain) mem[wb_idx[head]] <= wb_data[head];
  end

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    fwd  = mem[idx];
    slot = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      slot = head + ptr_t'(i);
      if ((5'(i) < count) && (wb_idx[slot] == idx)) fwd = wb_data[slot];
    end
  end

  assign bus.wb_count = count;
  assign bus.wb_full  = (count == FULL_CNT);
  assign bus.wb_ovf   = ovf;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table through a scoreboard queue plus corner sequences.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  dmem_if bus ();

  dmem_responder #(.DEPTH_LOG2(10), .WB_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] d;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic [4:0]  exp_cnt;
    bit          exp_full;
    bit          exp_ovf;
  } vec_t;

  vec_t tbl [19];
  vec_t sb [$];

  function automatic vec_t mk(bit w, bit r, logic [31:0] a, logic [31:0] d, bit chk_rd,
                              logic [31:0] exp_rd, logic [4:0] exp_cnt, bit exp_full, bit exp_ovf);
    vec_t v;
    v.w = w; v.r = r; v.a = a; v.d = d; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    v.exp_cnt = exp_cnt; v.exp_full = exp_full; v.exp_ovf = exp_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    bus.mem_w_en   = w;
    bus.mem_r_en   = r;
    bus.mem_addr   = a;
    bus.mem_w_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   budget;
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    // outputs are the pre-edge view for the inputs in the same row
    tbl[0]  = mk(1, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        0, 0, 0);
    tbl[1]  = mk(0, 0, 32'h10, 32'h0,        1, 32'hDEADBEEF, 1, 0, 0);
    tbl[2]  = mk(0, 0, 32'h10, 32'h0,        1, 32'hDEADBEEF, 0, 0, 0);
    tbl[3]  = mk(1, 0, 32'h20, 32'h11111111, 0, 32'h0,        0, 0, 0);
    tbl[4]  = mk(0, 0, 32'h20, 32'h0,        1, 32'h11111111, 1, 0, 0);
    tbl[5]  = mk(1, 1, 32'h00, 32'h1,        0, 32'h0,        0, 0, 0);
    tbl[6]  = mk(1, 1, 32'h04, 32'h2,        0, 32'h0,        1, 0, 0);
    tbl[7]  = mk(1, 1, 32'h08, 32'h3,        0, 32'h0,        2, 0, 0);
    tbl[8]  = mk(1, 1, 32'h00, 32'h4,        1, 32'h1,        3, 0, 0);
    tbl[9]  = mk(0, 1, 32'h00, 32'h0,        1, 32'h4,        4, 1, 0);
    tbl[10] = mk(0, 1, 32'h04, 32'h0,        1, 32'h2,        4, 1, 0);
    tbl[11] = mk(1, 1, 32'h20, 32'h55,       1, 32'h11111111, 4, 1, 0);
    tbl[12] = mk(0, 1, 32'h20, 32'h0,        1, 32'h11111111, 4, 1, 1);
    tbl[13] = mk(0, 0, 32'h00, 32'h0,        1, 32'h4,        4, 1, 1);
    tbl[14] = mk(0, 0, 32'h00, 32'h0,        1, 32'h4,        3, 0, 1);
    tbl[15] = mk(0, 0, 32'h04, 32'h0,        1, 32'h2,        2, 0, 1);
    tbl[16] = mk(0, 0, 32'h00, 32'h0,        1, 32'h4,        1, 0, 1);
    tbl[17] = mk(0, 0, 32'h00, 32'h0,        1, 32'h4,        0, 0, 1);
    tbl[18] = mk(0, 0, 32'h08, 32'h0,        1, 32'h3,        0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", {27'b0, bus.wb_count}, 32'd0);
    chk("reset_full", {31'b0, bus.wb_full}, 32'd0);
    chk("reset_ovf", {31'b0, bus.wb_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      sb.push_back(tbl[i]);
      #1;
      e = sb.pop_front();
      if (e.chk_rd) chk($sformatf("vec%0d_rdata", i), bus.mem_r_data, e.exp_rd);
      chk($sformatf("vec%0d_count", i), {27'b0, bus.wb_count}, {27'b0, e.exp_cnt});
      chk($sformatf("vec%0d_full", i), {31'b0, bus.wb_full}, {31'b0, e.exp_full});
      chk($sformatf("vec%0d_ovf", i), {31'b0, bus.wb_ovf}, {31'b0, e.exp_ovf});
    end

    // three stores held in the buffer, then an asynchronous reset mid-cycle
    @(negedge clk); drive(1, 1, 32'h10, 32'hAAAA0001);
    @(negedge clk); drive(1, 1, 32'h20, 32'hAAAA0002);
    @(negedge clk); drive(1, 1, 32'h00, 32'hAAAA0003);
    @(negedge clk); drive(0, 1, 32'h10, 32'h0);
    #1;
    chk("pre_rst_count", {27'b0, bus.wb_count}, 32'd3);
    chk("pre_rst_fwd", bus.mem_r_data, 32'hAAAA0001);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_count", {27'b0, bus.wb_count}, 32'd0);
    chk("async_rst_ovf", {31'b0, bus.wb_ovf}, 32'd0);
    chk("async_rst_rdata", bus.mem_r_data, 32'hDEADBEEF);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 32'h20, 32'h0);
    #1 chk("post_rst_arr20", bus.mem_r_data, 32'h11111111);
    drive(0, 0, 32'h00, 32'h0);
    #1 chk("post_rst_arr00", bus.mem_r_data, 32'h4);
    @(negedge clk); drive(1, 1, 32'h10, 32'hCAFE0000);
    @(negedge clk); drive(0, 1, 32'h10, 32'h0);
    #1;
    chk("resume_count", {27'b0, bus.wb_count}, 32'd1);
    chk("resume_fwd", bus.mem_r_data, 32'hCAFE0000);
    @(negedge clk); drive(0, 0, 32'h10, 32'h0);
    @(negedge clk);
    #1;
    chk("resume_drained", {27'b0, bus.wb_count}, 32'd0);
    chk("resume_arr10", bus.mem_r_data, 32'hCAFE0000);

    // full buffer with a drain in the same cycle still accepts the store
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1, 1, 32'h40 + 32'(4 * i), 32'h100 + 32'(i));
    end
    @(negedge clk); drive(1, 0, 32'h24, 32'h24242424);
    #1;
    chk("full_before", {31'b0, bus.wb_full}, 32'd1);
    @(negedge clk); drive(0, 0, 32'h24, 32'h0);
    #1;
    chk("full_drain_count", {27'b0, bus.wb_count}, 32'd4);
    chk("full_drain_ovf", {31'b0, bus.wb_ovf}, 32'd0);
    chk("full_drain_fwd", bus.mem_r_data, 32'h24242424);
    budget = 20;
    while (bus.wb_count != 5'd0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    chk("drain_in_budget", {31'b0, (budget > 0)}, 32'd1);
    chk("drain_arr24", bus.mem_r_data, 32'h24242424);
    drive(0, 0, 32'h4C, 32'h0);
    #1 chk("drain_arr4c", bus.mem_r_data, 32'h103);

`ifdef DMEM_CYCLE_CNT_EN
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1 drive(0, 1, 32'hFFFF_FFF0, 32'h0);
    #1 chk("cycle_cnt_100", bus.mem_r_data, 32'd100);
    drive(1, 1, 32'hFFFF_FFF0, 32'h5A5A5A5A);
    @(posedge clk);
    #1 drive(0, 0, 32'hFFFF_FFF0, 32'h0);
    #1;
    chk("cnt_store_count", {27'b0, bus.wb_count}, 32'd0);
    chk("cnt_store_ovf", {31'b0, bus.wb_ovf}, 32'd0);
`else
    @(negedge clk); drive(1, 0, 32'hFFFF_FFF0, 32'h5A5A5A5A);
    @(negedge clk); drive(0, 1, 32'h0000_0FF0, 32'h0);
    #1;
    chk("top_word_count", {27'b0, bus.wb_count}, 32'd1);
    chk("top_word_alias", bus.mem_r_data, 32'h5A5A5A5A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
